// File: rtl/trace_capture.sv
// Commit-trace sink: captures trace records into a FIFO with a discontinuity tag
// and serves them to a debug reader over a valid/ready port.
//   state      | meaning
//   ST_IDLE    | not capturing, waiting for arm
//   ST_ARMED   | FIFO cleared, waiting for the first captured (optionally triggered) record
//   ST_CAPTURE | every trace record is captured
//   ST_DONE    | capture ended by stop or by filling without wrap; waits for arm
module trace_capture #(
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_arm,
  input  logic          i_stop,
  input  logic          i_wrap,
  input  logic          i_trig_en,
  input  logic [31:0]   i_trig_addr,
  input  logic          i_trace_val,
  input  logic [31:0]   i_trace_addr,
  input  logic [31:0]   i_trace_inst,
  input  logic [31:0]   i_trace_data,
  output logic          o_rd_val,
  input  logic          i_rd_rdy,
  output logic [31:0]   o_rd_addr,
  output logic [31:0]   o_rd_inst,
  output logic [31:0]   o_rd_data,
  output logic          o_rd_disc,
  output logic [1:0]    o_state,
  output logic [CW-1:0] o_count,
  output logic [15:0]   o_drop_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t         r_state;
  logic [AW-1:0]  r_head;
  logic [AW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic [15:0]    r_drop_count;
  logic [31:0]    r_prev_addr;
  logic           r_prev_seen;

  logic [31:0]    r_mem_addr [DEPTH];
  logic [31:0]    r_mem_inst [DEPTH];
  logic [31:0]    r_mem_data [DEPTH];
  logic           r_mem_disc [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_trig_hit;
  logic w_cap;
  logic w_store;
  logic w_drop;
  logic w_fill_stop;
  logic w_disc;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_pop      = !w_empty && i_rd_rdy && !i_arm;
  assign w_trig_hit = !i_trig_en || (i_trace_addr == i_trig_addr);
  assign w_cap      = i_trace_val && !i_arm && !i_stop &&
                      ((r_state == ST_CAPTURE) || ((r_state == ST_ARMED) && w_trig_hit));
  // A full FIFO without a same-cycle pop only accepts a record when overwriting is allowed.
  assign w_store     = w_cap && (!w_full || w_pop || i_wrap);
  assign w_drop      = w_cap && w_full && !w_pop && i_wrap;
  assign w_fill_stop = w_cap && !i_wrap && !w_pop && (r_count >= CW'(DEPTH - 1));
  assign w_disc      = !r_prev_seen || (i_trace_addr != (r_prev_addr + 32'd4));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_drop_count <= '0;
      r_prev_addr  <= '0;
      r_prev_seen  <= 1'b0;
    end else begin
      if (i_trace_val) begin
        r_prev_addr <= i_trace_addr;
        r_prev_seen <= 1'b1;
      end
      if (i_arm) begin
        r_state      <= ST_ARMED;
        r_head       <= '0;
        r_tail       <= '0;
        r_count      <= '0;
        r_drop_count <= '0;
        r_prev_seen  <= 1'b0;
      end else begin
        if (w_store) r_tail <= r_tail + AW'(1);
        if (w_pop || w_drop) r_head <= r_head + AW'(1);
        if (w_store && !w_pop && !w_drop) r_count <= r_count + CW'(1);
        else if (!w_store && w_pop) r_count <= r_count - CW'(1);
        if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;

        if (i_stop) begin
          if (r_state == ST_ARMED) r_state <= ST_IDLE;
          else if (r_state == ST_CAPTURE) r_state <= ST_DONE;
        end else if (w_cap) begin
          if (w_fill_stop) r_state <= ST_DONE;
          else if (r_state == ST_ARMED) r_state <= ST_CAPTURE;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_store) begin
      r_mem_addr[r_tail] <= i_trace_addr;
      r_mem_inst[r_tail] <= i_trace_inst;
      r_mem_data[r_tail] <= i_trace_data;
      r_mem_disc[r_tail] <= w_disc;
    end
  end

  assign o_rd_val     = !w_empty;
  assign o_rd_addr    = r_mem_addr[r_head];
  assign o_rd_inst    = r_mem_inst[r_head];
  assign o_rd_data    = r_mem_data[r_head];
  assign o_rd_disc    = r_mem_disc[r_head];
  assign o_state      = r_state;
  assign o_count      = r_count;
  assign o_drop_count = r_drop_count;

endmodule
